ifetch_ctrl: RTL

- Fetch sequencer for the word-indexed instruction memory (combinational read: `address` in, `instruction` out, same cycle).
- Owns the program counter and drives the memory address.
- Captures each fetched word with its PC into a small prefetch FIFO.
- Presents entries to decode over a valid/ready handshake; supports start/stop, branch redirect with flush, and PC wrap/bound handling.

---
 rtl/ifetch_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads a combinational instruction memory and
// buffers {pc, word} pairs in a small FIFO for decode. Define IFETCH_BOUND_CHECK_EN for PC bound faulting.
module ifetch_ctrl #(
  parameter int MEM_WORDS  = 100,
  parameter int RESET_PC   = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] address,
  input  logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        busy,
  output logic [31:0] fetch_count,
  output logic        fault
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [31:0]   RESET_PC_C = 32'(RESET_PC);

`ifdef IFETCH_BOUND_CHECK_EN
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FAULT} state_t;
  localparam logic [31:0] MEM_WORDS_C = 32'(MEM_WORDS);
`else
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [31:0] LAST_PC = 32'(MEM_WORDS - 1);
`endif

  state_t          state;
  logic [31:0]     pc;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_next;
  logic [31:0]     fifo_instr [FIFO_DEPTH];
  logic [31:0]     fifo_pc    [FIFO_DEPTH];
  logic            redirect_act, pop, push, pc_ok;
  logic [31:0]     pc_next;

  assign redirect_act = redirect_valid && (state == RUN || state == DRAIN);
  assign pop          = (count != '0) && instr_ready && !redirect_act;

`ifdef IFETCH_BOUND_CHECK_EN
  assign pc_ok   = (pc < MEM_WORDS_C);
  assign pc_next = pc + 32'd1;
`else
  assign pc_ok   = 1'b1;
  assign pc_next = (pc == LAST_PC) ? 32'd0 : pc + 32'd1;
`endif

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = (state == RUN) && !redirect_act && pc_ok && ((count < DEPTH_C) || pop);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: non-blocking assignments throughout sequential logic so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC_C;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_count <= '0;
`ifdef IFETCH_BOUND_CHECK_EN
      fault       <= 1'b0;
`endif
    end else if (redirect_act) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      pc     <= redirect_pc;
      if (state == RUN && stop) state <= DRAIN;
    end else begin
      count <= count_next;
      if (push) begin
        wr_ptr      <= wr_ptr + PW'(1);
        pc          <= pc_next;
        fetch_count <= fetch_count + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          pc    <= RESET_PC_C;
        end
        RUN: begin
`ifdef IFETCH_BOUND_CHECK_EN
          if (!pc_ok) begin
            state <= FAULT;
            fault <= 1'b1;
          end else if (stop) state <= DRAIN;
`else
          if (stop) state <= DRAIN;
`endif
        end
        DRAIN: if (count_next == '0) state <= IDLE;
        default: state <= state;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= instruction;
      fifo_pc[wr_ptr]    <= pc;
    end
  end

`ifndef IFETCH_BOUND_CHECK_EN
  assign fault = 1'b0;
`endif

  assign address     = pc;
  assign busy        = (state != IDLE);
  assign instr_valid = (count != '0);
  assign instr_out   = instr_valid ? fifo_instr[rd_ptr] : 32'd0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : 32'd0;

endmodule
